// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the memory port arbiter
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA_BUSY  = 3'd1,
        DATA_DONE  = 3'd2,
        INSTR_BUSY = 3'd3,
        INSTR_DONE = 3'd4
    } arb_state_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enable flop with synchronous active-high reset
module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset has priority over the load enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - single-port memory arbiter between fetch and memory stages
module memory_port_arbiter
    import riscv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        InstrReqF,
    input  logic [31:0] PcF,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteEnM,
    output logic [31:0] ReadDataM,
    output logic        DataValidM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    arb_state_t  r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_data_valid;
    logic        r_instr_valid;

    logic        w_data_stall;
    logic        w_instr_stall;
    logic        w_data_cap;
    logic        w_instr_cap;

    // A requester stays stalled until the cycle its access is reported done.
    assign w_data_stall  = MemReqM   && (r_state != DATA_DONE);
    assign w_instr_stall = InstrReqF && (r_state != INSTR_DONE);

    // Capture read data only for loads and fetches completing this cycle.
    assign w_data_cap  = (r_state == DATA_BUSY)  && MemAck && !r_mem_we;
    assign w_instr_cap = (r_state == INSTR_BUSY) && MemAck;

    // Arbitration FSM: data wins ties, no preemption, DONE always returns to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_data_valid  <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_instr_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (MemReqM) begin
                        r_state     <= DATA_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= MemWriteM;
                        r_mem_addr  <= AddrM;
                        r_mem_wdata <= WriteDataM;
                        r_mem_be    <= ByteEnM;
                    end else if (InstrReqF) begin
                        r_state     <= INSTR_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= PcF;
                        r_mem_wdata <= '0;
                        r_mem_be    <= BE_WORD;
                    end
                end
                DATA_BUSY: begin
                    if (MemAck) begin
                        r_state      <= DATA_DONE;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_data_valid <= 1'b1;
                    end
                end
                INSTR_BUSY: begin
                    if (MemAck) begin
                        r_state       <= INSTR_DONE;
                        r_mem_req     <= 1'b0;
                        r_mem_we      <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                DATA_DONE:  r_state <= IDLE;
                INSTR_DONE: r_state <= IDLE;
                default:    r_state <= IDLE;
            endcase
        end
    end

    flopenr #(.WIDTH(32)) u_read_data (
        .i_clk   (clock),
        .i_reset (reset),
        .i_en    (w_data_cap),
        .i_d     (MemRData),
        .o_q     (ReadDataM)
    );

    flopenr #(.WIDTH(32)) u_instr (
        .i_clk   (clock),
        .i_reset (reset),
        .i_en    (w_instr_cap),
        .i_d     (MemRData),
        .o_q     (InstrF)
    );

    assign StallF      = w_data_stall || w_instr_stall;
    assign StallD      = w_data_stall || w_instr_stall;
    assign StallE      = w_data_stall;
    assign StallM      = w_data_stall;
    assign FlushW      = w_data_stall;
    assign FlushE      = w_instr_stall && !w_data_stall;

    assign MemReq      = r_mem_req;
    assign MemWe       = r_mem_we;
    assign MemAddr     = r_mem_addr;
    assign MemWData    = r_mem_wdata;
    assign MemBe       = r_mem_be;
    assign DataValidM  = r_data_valid;
    assign InstrValidF = r_instr_valid;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

    localparam logic [31:0] PC_C   = 32'h0000_0400;
    localparam logic [31:0] ADDR_C = 32'h0000_0100;
    localparam logic [31:0] WD_C   = 32'hCAFE_F00D;
    localparam logic [3:0]  BE_C   = 4'b0011;

    logic        clock = 1'b0;
    logic        reset;
    logic        InstrReqF;
    logic [31:0] PcF;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] ReadDataM;
    logic        DataValidM;
    logic        StallF, StallD, StallE, StallM, FlushE, FlushW;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBe;
    logic [31:0] MemRData;
    logic        MemAck;

    memory_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .InstrReqF   (InstrReqF),
        .PcF         (PcF),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .MemReqM     (MemReqM),
        .MemWriteM   (MemWriteM),
        .AddrM       (AddrM),
        .WriteDataM  (WriteDataM),
        .ByteEnM     (ByteEnM),
        .ReadDataM   (ReadDataM),
        .DataValidM  (DataValidM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemBe       (MemBe),
        .MemRData    (MemRData),
        .MemAck      (MemAck)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ireq, dreq, dwe, ack;
        logic [31:0] rdata;
        logic        e_sf, e_sm, e_fe, e_mr, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_dv, e_iv;
        logic        push_d, push_i;
        logic [31:0] push_val;
    } vec_t;

    typedef struct {
        logic        is_instr;
        logic [31:0] val;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ireq, input logic dreq, input logic dwe, input logic ack,
                       input logic [31:0] rdata,
                       input logic sf, input logic sm, input logic fe, input logic mr, input logic we,
                       input logic [31:0] addr, input logic [3:0] be,
                       input logic dv, input logic iv,
                       input logic pd, input logic pi, input logic [31:0] pv);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.ack = ack; v.rdata = rdata;
        v.e_sf = sf; v.e_sm = sm; v.e_fe = fe; v.e_mr = mr; v.e_we = we;
        v.e_addr = addr; v.e_be = be; v.e_dv = dv; v.e_iv = iv;
        v.push_d = pd; v.push_i = pi; v.push_val = pv;
        vecs.push_back(v);
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expected completion.
    always @(negedge clock) begin
        #2;
        if (reset === 1'b0 && (DataValidM === 1'b1 || InstrValidF === 1'b1)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_valid: got dv=%b iv=%b want none", DataValidM, InstrValidF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_kind", {31'd0, InstrValidF}, {31'd0, e.is_instr});
                if (e.is_instr) chk("sb_instr", InstrF, e.val);
                else            chk("sb_rdata", ReadDataM, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; InstrReqF = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; MemAck = 1'b0;
        MemRData = '0; PcF = PC_C; AddrM = ADDR_C; WriteDataM = WD_C; ByteEnM = BE_C;

        //   ireq dreq dwe ack rdata         sf sm fe mr we addr    be     dv iv pd pi pv
        // Load with zero-wait memory
        add(0, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 32'hDEADBEEF,   1, 1, 0, 1, 0, ADDR_C, BE_C,  0, 0, 1, 0, 32'hDEADBEEF);
        add(0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        // Store with three wait cycles; read data must not change
        add(0, 1, 1, 0, 32'h0,          1, 1, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 1, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 1, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 1, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 1, 32'h55555555,   1, 1, 0, 1, 1, ADDR_C, BE_C,  0, 0, 1, 0, 32'hDEADBEEF);
        add(0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        // Simultaneous requests: data first, then fetch
        add(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(1, 1, 0, 1, 32'h11111111,   1, 1, 0, 1, 0, ADDR_C, BE_C,  0, 0, 1, 0, 32'h11111111);
        add(1, 1, 0, 0, 32'h0,          1, 0, 1, 0, 0, ADDR_C, BE_C,  1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,          1, 0, 1, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(1, 0, 0, 1, 32'h00000013,   1, 0, 1, 1, 0, PC_C,   4'hF,  0, 0, 0, 1, 32'h00000013);
        add(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, PC_C,   4'hF,  0, 1, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, PC_C,   4'hF,  0, 0, 0, 0, 32'h0);
        // Data request arriving during a fetch waits for the fetch
        add(1, 0, 0, 0, 32'h0,          1, 0, 1, 0, 0, PC_C,   4'hF,  0, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,          1, 0, 1, 1, 0, PC_C,   4'hF,  0, 0, 0, 0, 32'h0);
        add(1, 1, 0, 0, 32'h0,          1, 1, 0, 1, 0, PC_C,   4'hF,  0, 0, 0, 0, 32'h0);
        add(1, 1, 0, 1, 32'h00A00093,   1, 1, 0, 1, 0, PC_C,   4'hF,  0, 0, 0, 1, 32'h00A00093);
        add(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, PC_C,   4'hF,  0, 1, 0, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 32'h00000077,   1, 1, 0, 1, 0, ADDR_C, BE_C,  0, 0, 1, 0, 32'h00000077);
        add(0, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        // Stray acknowledge while idle is ignored
        add(0, 0, 0, 1, 32'h00000BAD,   0, 0, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, ADDR_C, BE_C,  0, 0, 0, 0, 32'h0);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("rst_memwe", {31'd0, MemWe}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        chk("rst_membe", {28'd0, MemBe}, 32'd0);
        chk("rst_instrf", InstrF, 32'd0);
        chk("rst_readdata", ReadDataM, 32'd0);
        chk("rst_valids", {30'd0, DataValidM, InstrValidF}, 32'd0);
        chk("rst_stalls", {26'd0, StallF, StallD, StallE, StallM, FlushE, FlushW}, 32'd0);

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clock);
            InstrReqF = v.ireq; MemReqM = v.dreq; MemWriteM = v.dwe;
            MemAck = v.ack; MemRData = v.rdata;
            #1;
            chk($sformatf("v%0d_stallf", i), {31'd0, StallF}, {31'd0, v.e_sf});
            chk($sformatf("v%0d_stalld", i), {31'd0, StallD}, {31'd0, v.e_sf});
            chk($sformatf("v%0d_stalle", i), {31'd0, StallE}, {31'd0, v.e_sm});
            chk($sformatf("v%0d_stallm", i), {31'd0, StallM}, {31'd0, v.e_sm});
            chk($sformatf("v%0d_flushw", i), {31'd0, FlushW}, {31'd0, v.e_sm});
            chk($sformatf("v%0d_flushe", i), {31'd0, FlushE}, {31'd0, v.e_fe});
            chk($sformatf("v%0d_memreq", i), {31'd0, MemReq}, {31'd0, v.e_mr});
            chk($sformatf("v%0d_memwe", i), {31'd0, MemWe}, {31'd0, v.e_we});
            chk($sformatf("v%0d_dvalid", i), {31'd0, DataValidM}, {31'd0, v.e_dv});
            chk($sformatf("v%0d_ivalid", i), {31'd0, InstrValidF}, {31'd0, v.e_iv});
            if (v.e_mr) begin
                chk($sformatf("v%0d_memaddr", i), MemAddr, v.e_addr);
                chk($sformatf("v%0d_membe", i), {28'd0, MemBe}, {28'd0, v.e_be});
                if (v.e_we) chk($sformatf("v%0d_memwdata", i), MemWData, WD_C);
            end
            if (v.push_d) sb.push_back('{is_instr: 1'b0, val: v.push_val});
            if (v.push_i) sb.push_back('{is_instr: 1'b1, val: v.push_val});
        end

        // Reset in the middle of a data access; the late acknowledge is ignored
        @(negedge clock);
        InstrReqF = 1'b0; MemReqM = 1'b1; MemWriteM = 1'b0; MemAck = 1'b0;
        #1;
        chk("mid_idle_stallm", {31'd0, StallM}, 32'd1);
        @(negedge clock);
        #1;
        chk("mid_busy_memreq", {31'd0, MemReq}, 32'd1);
        chk("mid_busy_addr", MemAddr, ADDR_C);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; MemReqM = 1'b0; MemAck = 1'b1; MemRData = 32'h0BAD_BAD0;
        #1;
        chk("mid_rst_memreq", {31'd0, MemReq}, 32'd0);
        chk("mid_rst_memaddr", MemAddr, 32'd0);
        chk("mid_rst_readdata", ReadDataM, 32'd0);
        chk("mid_rst_dvalid", {31'd0, DataValidM}, 32'd0);
        @(negedge clock);
        MemAck = 1'b0;
        #1;
        chk("mid_late_memreq", {31'd0, MemReq}, 32'd0);
        chk("mid_late_readdata", ReadDataM, 32'd0);
        chk("mid_late_dvalid", {31'd0, DataValidM}, 32'd0);
        chk("mid_late_stallm", {31'd0, StallM}, 32'd0);
        @(negedge clock);
        #3;
        chk("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
